// File: rtl/sweep_acq_controller_if.sv
// sweep_acq_controller_if: command, DAC, slow-control and data-path signals of the sweep acquisition controller
interface sweep_acq_controller_if #(
  parameter int DAC_WIDTH     = 10,
  parameter int NUM_DAC       = 3,
  parameter int SEL_WIDTH     = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int PKT_CNT_WIDTH = 16
);
  logic                         SweepStart;
  logic                         SweepStop;
  logic [SEL_WIDTH-1:0]         DacSelect;
  logic [DAC_WIDTH-1:0]         StartDac;
  logic [DAC_WIDTH-1:0]         EndDac;
  logic [DAC_WIDTH-1:0]         DacStep;
  logic [PKT_CNT_WIDTH-1:0]     MaxPackageNumber;
  logic [NUM_DAC*DAC_WIDTH-1:0] UsbDac;
  logic [NUM_DAC*DAC_WIDTH-1:0] OutDac;
  logic                         SCParameterLoad;
  logic                         MicrorocConfigDone;
  logic                         MicrorocAcqStartStop;
  logic [DATA_WIDTH-1:0]        ParallelData;
  logic                         ParallelData_en;
  logic                         UsbFifoFull;
  logic [DATA_WIDTH-1:0]        SweepData;
  logic                         SweepData_en;
  logic [DAC_WIDTH-1:0]         CurrentDac;
  logic                         SweepBusy;
  logic                         SweepDone;
  logic                         Overflow;
  logic                         ConfigTimeout;
  modport master (
    input  SweepStart, SweepStop, DacSelect, StartDac, EndDac, DacStep, MaxPackageNumber, UsbDac,
           MicrorocConfigDone, ParallelData, ParallelData_en, UsbFifoFull,
    output OutDac, SCParameterLoad, MicrorocAcqStartStop, SweepData, SweepData_en, CurrentDac,
           SweepBusy, SweepDone, Overflow, ConfigTimeout
  );
  modport slave (
    output SweepStart, SweepStop, DacSelect, StartDac, EndDac, DacStep, MaxPackageNumber, UsbDac,
           MicrorocConfigDone, ParallelData, ParallelData_en, UsbFifoFull,
    input  OutDac, SCParameterLoad, MicrorocAcqStartStop, SweepData, SweepData_en, CurrentDac,
           SweepBusy, SweepDone, Overflow, ConfigTimeout
  );
endinterface

// File: rtl/sweep_acq_controller.sv
// sweep_acq_controller: steps one threshold DAC through a code range, reconfiguring and acquiring a packet batch per code
module sweep_acq_controller #(
  parameter int DAC_WIDTH     = 10,
  parameter int NUM_DAC       = 3,
  parameter int SEL_WIDTH     = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int PKT_CNT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PKT_END_WORD = 16'hFFFF,
  parameter logic [DATA_WIDTH-DAC_WIDTH-1:0] HEADER_TAG = 6'b110011,
  parameter int CFG_TIMEOUT   = 1000000,
  parameter int DRAIN_CYCLES  = 64
) (
  input logic Clk,
  input logic reset,
  sweep_acq_controller_if.master bus
);
  localparam int CW = $clog2(CFG_TIMEOUT + 1);
  localparam int RW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CFG_LAST = CW'(CFG_TIMEOUT - 1);
  localparam logic [RW-1:0] DRAIN_LAST = RW'(DRAIN_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_CFG, HEADER, ACQ, STOP, NEXT, DONE} state_t;
  state_t state;
  logic startPrev, abortReq;
  logic [DAC_WIDTH-1:0] endDac, dacStep;
  logic [SEL_WIDTH-1:0] dacSel;
  logic [PKT_CNT_WIDTH-1:0] maxPkt, pktCnt;
  logic [CW-1:0] cfgCnt;
  logic [RW-1:0] drainCnt;
  logic [DAC_WIDTH:0] nextSum;
  logic fwd, endWord, lastPkt;
  assign nextSum = {1'b0, bus.CurrentDac} + {1'b0, dacStep};
  assign fwd = state == ACQ || state == STOP;
  assign endWord = bus.ParallelData_en && bus.ParallelData == PKT_END_WORD;
  assign lastPkt = pktCnt + PKT_CNT_WIDTH'(1) == maxPkt;
  always_comb begin
    bus.OutDac = bus.UsbDac;
    for (int i = 0; i < NUM_DAC; i++)
      bus.OutDac[i*DAC_WIDTH +: DAC_WIDTH] = bus.SweepBusy && 32'(dacSel) == i ? bus.CurrentDac : bus.UsbDac[i*DAC_WIDTH +: DAC_WIDTH];
  end
  always_ff @(posedge Clk) begin
    startPrev <= bus.SweepStart;
    if (reset) begin
      state <= IDLE;
      bus.SCParameterLoad <= 1'b0;
      bus.MicrorocAcqStartStop <= 1'b0;
      bus.SweepData <= '0;
      bus.SweepData_en <= 1'b0;
      bus.CurrentDac <= '0;
      bus.SweepBusy <= 1'b0;
      bus.SweepDone <= 1'b0;
      bus.Overflow <= 1'b0;
      bus.ConfigTimeout <= 1'b0;
      abortReq <= 1'b0;
      pktCnt <= '0;
      cfgCnt <= '0;
      drainCnt <= '0;
    end else begin
      bus.SCParameterLoad <= 1'b0;
      bus.SweepDone <= 1'b0;
      bus.SweepData_en <= fwd && bus.ParallelData_en && !bus.UsbFifoFull;
      if (fwd && bus.ParallelData_en && !bus.UsbFifoFull) bus.SweepData <= bus.ParallelData;
      if (fwd && bus.ParallelData_en && bus.UsbFifoFull) bus.Overflow <= 1'b1;
      case (state)
        IDLE: if (bus.SweepStart && !startPrev) begin
          state <= LOAD;
          bus.SCParameterLoad <= 1'b1;
          bus.SweepBusy <= 1'b1;
          bus.CurrentDac <= bus.StartDac;
          bus.Overflow <= 1'b0;
          bus.ConfigTimeout <= 1'b0;
          endDac <= bus.EndDac;
          dacStep <= bus.DacStep == '0 ? DAC_WIDTH'(1) : bus.DacStep;
          dacSel <= 32'(bus.DacSelect) < NUM_DAC ? bus.DacSelect : '0;
          maxPkt <= bus.MaxPackageNumber;
          pktCnt <= '0;
          abortReq <= 1'b0;
        end
        LOAD: if (bus.SweepStop) begin state <= DONE; bus.SweepDone <= 1'b1; bus.SweepBusy <= 1'b0; end
          else begin state <= WAIT_CFG; cfgCnt <= '0; end
        WAIT_CFG: if (bus.SweepStop) begin state <= DONE; bus.SweepDone <= 1'b1; bus.SweepBusy <= 1'b0; end
          else if (bus.MicrorocConfigDone) state <= HEADER;
          else if (cfgCnt == CFG_LAST) begin
            bus.ConfigTimeout <= 1'b1;
            state <= DONE; bus.SweepDone <= 1'b1; bus.SweepBusy <= 1'b0;
          end else cfgCnt <= cfgCnt + CW'(1);
        HEADER: if (bus.SweepStop) begin state <= DONE; bus.SweepDone <= 1'b1; bus.SweepBusy <= 1'b0; end
          else if (!bus.UsbFifoFull) begin
            bus.SweepData <= {HEADER_TAG, bus.CurrentDac};
            bus.SweepData_en <= 1'b1;
            if (maxPkt == '0) state <= NEXT;
            else begin state <= ACQ; bus.MicrorocAcqStartStop <= 1'b1; end
          end
        ACQ: begin
          if (endWord) pktCnt <= pktCnt + PKT_CNT_WIDTH'(1);
          // an abort arriving with the final packet still takes the abort path
          if (bus.SweepStop || (endWord && lastPkt)) begin
            state <= STOP;
            bus.MicrorocAcqStartStop <= 1'b0;
            drainCnt <= '0;
            abortReq <= bus.SweepStop;
          end
        end
        STOP: begin
          abortReq <= abortReq || bus.SweepStop;
          if (drainCnt != DRAIN_LAST) drainCnt <= drainCnt + RW'(1);
          else if (abortReq || bus.SweepStop) begin state <= DONE; bus.SweepDone <= 1'b1; bus.SweepBusy <= 1'b0; end
          else state <= NEXT;
        end
        NEXT: if (bus.SweepStop || nextSum[DAC_WIDTH] || nextSum[DAC_WIDTH-1:0] > endDac) begin
            state <= DONE; bus.SweepDone <= 1'b1; bus.SweepBusy <= 1'b0;
          end else begin
            state <= LOAD;
            bus.CurrentDac <= nextSum[DAC_WIDTH-1:0];
            bus.SCParameterLoad <= 1'b1;
            pktCnt <= '0;
          end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
